// File: rtl/led_pkg.sv
// Shared definitions for the LED frame path: sequencer states, clock rate,
// pixel layout in SPRAM and the default latch-gap length.
package led_pkg;

  localparam int CLK_HZ           = 48_000_000;
  localparam int WORDS_PER_PIXEL  = 2;
  // 300 us strip latch gap expressed in system clocks
  localparam int LATCH_CYCLES_DEF = (CLK_HZ / 1_000_000) * 300;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_LATCH  = 3'd4
  } state_e;

  function automatic logic [13:0] pixel_addr(input logic [13:0] base, input logic [13:0] idx);
    logic [31:0] off;
    off = 32'(idx) * 32'(WORDS_PER_PIXEL);
    return base + off[13:0];
  endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// SPRAM read port, driver handshake and frame control between pixel_fetch
// (master) and its environment (slave).
interface pixel_fetch_if;
  logic        start;
  logic        loop;
  logic [13:0] addr;
  logic [15:0] rd_data;
  logic [23:0] rgb;
  logic        load;
  logic        done;
  logic        strip_rst_n;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, loop, rd_data, done,
    output addr, rgb, load, strip_rst_n, busy, frame_done
  );

  modport slave (
    output start, loop, rd_data, done,
    input  addr, rgb, load, strip_rst_n, busy, frame_done
  );
endinterface

// File: rtl/spram_pixel_reader.sv
// Two-word SPRAM pixel read: issues base then base+1, keeps word0 and presents
// the assembled 24-bit colour with valid in the cycle word1 is on DO.
module spram_pixel_reader #(
  parameter logic [13:0] RST_ADDR = 14'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [13:0] base,
  output logic [13:0] addr,
  input  logic [15:0] rd_data,
  output logic [23:0] pix,
  output logic        valid
);

  logic [1:0]  ph_q, ph_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] word0_q, word0_d;

  // read phase sequencing: 1 = base issued, 2 = word0 on DO, 3 = word1 on DO
  always_comb begin
    ph_d    = ph_q;
    addr_d  = addr_q;
    word0_d = word0_q;
    case (ph_q)
      2'd0: begin
        if (go) begin
          addr_d = base;
          ph_d   = 2'd1;
        end else begin
          ph_d   = 2'd0;
        end
      end
      2'd1: begin
        addr_d = addr_q + 14'd1;
        ph_d   = 2'd2;
      end
      2'd2: begin
        word0_d = rd_data;
        ph_d    = 2'd3;
      end
      default: ph_d = 2'd0;
    endcase
  end

  // phase, address and word0 registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q    <= 2'd0;
      addr_q  <= RST_ADDR;
      word0_q <= 16'd0;
    end else begin
      ph_q    <= ph_d;
      addr_q  <= addr_d;
      word0_q <= word0_d;
    end
  end

  assign addr  = addr_q;
  assign valid = (ph_q == 2'd3);
  assign pix   = {rd_data[7:0], word0_q};

endmodule

// File: rtl/pixel_fetch.sv
// Frame sequencer: fetches pixels from SPRAM, hands them to the LED driver with
// load/done while prefetching the next one, then holds the latch gap.
module pixel_fetch
  import led_pkg::*;
#(
  parameter int          NUM_LEDS     = 60,
  parameter logic [13:0] BASE_ADDR    = 14'd0,
  parameter int          LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  pixel_fetch_if.master bus
);

  localparam int              CNT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [13:0]     NUM   = 14'(NUM_LEDS);

  state_e            state_q, state_d;
  logic [13:0]       idx_q, idx_d;          // pixels handed to the driver this frame
  logic [23:0]       stage_q, stage_d;
  logic              stage_ok_q, stage_ok_d;
  logic              done_seen_q, done_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              strip_q, strip_d;

  logic              rd_go;
  logic [13:0]       rd_base;
  logic [13:0]       rd_addr;
  logic [23:0]       rd_pix;
  logic              rd_valid;
  logic              pix_done;
  logic [13:0]       next_idx;

  spram_pixel_reader #(.RST_ADDR(BASE_ADDR)) u_reader (
    .clk     (clk),
    .reset   (reset),
    .go      (rd_go),
    .base    (rd_base),
    .addr    (rd_addr),
    .rd_data (bus.rd_data),
    .pix     (rd_pix),
    .valid   (rd_valid)
  );

  // next-state, staging and output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    stage_ok_d  = stage_ok_q;
    done_seen_d = done_seen_q;
    cnt_d       = cnt_q;
    rgb_d       = rgb_q;
    load_d      = 1'b0;
    rd_go       = 1'b0;
    rd_base     = BASE_ADDR;
    next_idx    = idx_q + 14'd1;
    // a done in the same cycle as load belongs to no pixel yet
    pix_done    = bus.done && !load_q && (state_q == ST_STREAM);

    if (rd_valid) begin
      stage_d    = rd_pix;
      stage_ok_d = 1'b1;
    end else begin
      stage_d    = stage_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          idx_d   = 14'd0;
          rd_go   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rd_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_LOAD: begin
        rgb_d       = stage_q;
        load_d      = 1'b1;
        stage_ok_d  = 1'b0;
        done_seen_d = 1'b0;
        idx_d       = next_idx;
        state_d     = ST_STREAM;
        if (next_idx < NUM) begin
          rd_go   = 1'b1;
          rd_base = pixel_addr(BASE_ADDR, next_idx);
        end else begin
          rd_go   = 1'b0;
        end
      end
      ST_STREAM: begin
        if (pix_done || done_seen_q) begin
          if (idx_q >= NUM) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else if (stage_ok_q || rd_valid) begin
            state_d = ST_LOAD;
          end else begin
            done_seen_d = 1'b1;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_LATCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (bus.loop) begin
            state_d = ST_FETCH;
            idx_d   = 14'd0;
            rd_go   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_LATCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    strip_d      = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_STREAM);
    frame_done_d = (state_d == ST_LATCH) && (cnt_d == LAST);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 14'd0;
      stage_q      <= 24'd0;
      stage_ok_q   <= 1'b0;
      done_seen_q  <= 1'b0;
      cnt_q        <= '0;
      rgb_q        <= 24'd0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      strip_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      stage_ok_q   <= stage_ok_d;
      done_seen_q  <= done_seen_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      strip_q      <= strip_d;
    end
  end

  assign bus.addr        = rd_addr;
  assign bus.rgb         = rgb_q;
  assign bus.load        = load_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.strip_rst_n = strip_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: SPRAM model, driver model with random
// done latency, and a monitor checking every load and frame_done.
module tb_pixel_fetch;

  localparam int          NUM_LEDS     = 3;
  localparam logic [13:0] BASE_ADDR    = 14'd6;
  localparam int          LATCH_CYCLES = 40;

  logic clk = 1'b0;
  logic reset;
  pixel_fetch_if bus();

  pixel_fetch #(
    .NUM_LEDS     (NUM_LEDS),
    .BASE_ADDR    (BASE_ADDR),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  always @(posedge clk) bus.rd_data <= mem[bus.addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_rgb_q [$];
  int          exp_cyc_q [$];
  int          exp_fd_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_pix(input int n);
    logic [15:0] w0, w1;
    w0 = mem[int'(BASE_ADDR) + 2*n];
    w1 = mem[int'(BASE_ADDR) + 2*n + 1];
    return {w1[7:0], w0};
  endfunction

  task automatic push_frame_rgb();
    for (int n = 0; n < NUM_LEDS; n++) exp_rgb_q.push_back(ref_pix(n));
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 2*NUM_LEDS; i++) mem[int'(BASE_ADDR) + i] = 16'($urandom);
  endtask

  // monitor: pops expectations whenever the DUT presents load or frame_done
  initial begin
    int low_run;
    logic [23:0] er;
    int ec;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        low_run = 0;
      end else begin
        if (bus.strip_rst_n) low_run = 0;
        else low_run++;
        if (bus.load) begin
          if (exp_rgb_q.size() == 0 || exp_cyc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_load: got rgb %0h with no pending pixel (cycle %0d)", bus.rgb, cyc);
          end else begin
            er = exp_rgb_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("load_rgb", bus.rgb, er);
            check("load_cycle", cyc, ec);
            check("busy_at_load", bus.busy, 1'b1);
          end
        end
        if (bus.frame_done) begin
          if (exp_fd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame_done: got pulse with none pending (cycle %0d)", cyc);
          end else begin
            ec = exp_fd_q.pop_front();
            check("frame_done_cycle", cyc, ec);
            check("latch_len", low_run, LATCH_CYCLES);
            check("busy_at_frame_done", bus.busy, 1'b1);
          end
        end
      end
    end
  end

  task automatic wait_load(output int lc, output bit ok);
    ok = 1'b0;
    lc = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.load) begin
        ok = 1'b1;
        lc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL load_timeout: got no load within 4000 cycles, expected one (cycle %0d)", cyc);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.start = 1'b1;
    push_frame_rgb();
    exp_cyc_q.push_back(cyc + 5);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // driver model; dmode 0: 1440-cycle shift, 1: done after 1 cycle, 2: random
  task automatic serve_frame(input int dmode, input bit loop_next, input bit start_in_stream);
    int lc, d, dd;
    bit ok;
    for (int n = 0; n < NUM_LEDS; n++) begin
      wait_load(lc, ok);
      if (!ok) return;
      d = (dmode == 0) ? 1440 : (dmode == 1) ? 1 : int'($urandom_range(1, 8));
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        bus.start = start_in_stream && (k == 0) && (d > 1);
      end
      if (n == NUM_LEDS - 1) bus.loop = loop_next;
      bus.done = 1'b1;
      dd = lc + d;
      if (n < NUM_LEDS - 1) begin
        exp_cyc_q.push_back((dd + 2 > lc + 4) ? dd + 2 : lc + 4);
      end else begin
        exp_fd_q.push_back(dd + LATCH_CYCLES);
        if (loop_next) begin
          push_frame_rgb();
          exp_cyc_q.push_back(dd + LATCH_CYCLES + 5);
        end
      end
      @(negedge clk);
      bus.done = 1'b0;
    end
  endtask

  task automatic wait_fd_idle();
    bit found;
    found = 1'b0;
    for (int i = 0; i < LATCH_CYCLES + 100; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: got no frame_done, expected one (cycle %0d)", cyc);
    end
    @(negedge clk);
    check("busy_after_frame", bus.busy, 1'b0);
    check("strip_after_frame", bus.strip_rst_n, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, bus.addr, BASE_ADDR);
    check({tag, "_rgb"}, bus.rgb, 24'd0);
    check({tag, "_load"}, bus.load, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_frame_done"}, bus.frame_done, 1'b0);
    check({tag, "_strip"}, bus.strip_rst_n, 1'b0);
  endtask

  initial begin
    int lc;
    bit ok;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.loop  = 1'b0;
    bus.done  = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // stray done while idle
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_addr", bus.addr, BASE_ADDR);

    // slow driver, known first pixel (upper byte of word1 ignored)
    randomize_mem();
    mem[BASE_ADDR]         = 16'hCEFF;
    mem[BASE_ADDR + 14'd1] = 16'hAB00;
    start_frame();
    serve_frame(0, 1'b0, 1'b0);
    wait_fd_idle();

    // fast driver: loads wait for prefetch
    randomize_mem();
    start_frame();
    serve_frame(1, 1'b0, 1'b0);
    wait_fd_idle();

    // random latency with a stray start while streaming
    randomize_mem();
    start_frame();
    serve_frame(2, 1'b0, 1'b1);
    wait_fd_idle();

    // looping frames, then stop
    randomize_mem();
    bus.loop = 1'b1;
    start_frame();
    serve_frame(2, 1'b1, 1'b0);
    serve_frame(1, 1'b1, 1'b0);
    serve_frame(2, 1'b0, 1'b0);
    wait_fd_idle();

    // reset mid-stream, then replay from pixel 0
    randomize_mem();
    start_frame();
    wait_load(lc, ok);
    repeat (2) @(negedge clk);
    exp_rgb_q.delete();
    exp_cyc_q.delete();
    exp_fd_q.delete();
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b1;
    start_frame();
    serve_frame(2, 1'b0, 1'b0);
    wait_fd_idle();

    check("drain_rgb", exp_rgb_q.size(), 0);
    check("drain_cyc", exp_cyc_q.size(), 0);
    check("drain_fd", exp_fd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Frame sequencer between the SPRAM pixel store and `led_string`/`led_driver`. Reads one 24-bit colour per LED from the single-port SPRAM (two 16-bit words per pixel), presents it on `rgb` with a `load`/`done` handshake, prefetches the next pixel while the current one is shifted out, then holds the strip in reset (latch gap) before reporting frame completion. Runs on the 48 MHz HSOSC clock.

## Interface
- `NUM_LEDS`, 60: pixels per frame (≥1).
- `BASE_ADDR`, 14'd0: SPRAM word address of pixel 0.
- `LATCH_CYCLES`, 14400: latch-gap length in clocks (300 µs at 48 MHz).
- `clk` in 1: 48 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin one frame; sampled only in IDLE.
- `loop` in 1: when high at the end of the latch gap, restart immediately.
- `addr` out 14: SPRAM address (registered).
- `rd_data` in 16: SPRAM `DO`.
- `rgb` out 24: pixel to driver, `{word1[7:0], word0[15:0]}`.
- `load` out 1: one-cycle pulse; `rgb` valid in that cycle and held until the next `load`.
- `done` in 1: one-cycle pulse from driver when the current pixel has been fully shifted.
- `strip_rst_n` out 1: low during IDLE and LATCH (driver held in reset), high while streaming.
- `busy` out 1: high from start acceptance through the `frame_done` cycle.
- `frame_done` out 1: one-cycle pulse at end of latch gap.

## Operation
- States: IDLE, FETCH, LOAD, STREAM, LATCH.
- Pixel n occupies words `BASE_ADDR+2n` (low 16 bits) and `BASE_ADDR+2n+1` (bits [7:0]; [15:8] ignored). `2*NUM_LEDS+BASE_ADDR ≤ 16384`; address arithmetic is 14-bit, no wrap in a legal configuration.
- IDLE: `start`=1 → FETCH for pixel 0, `busy`=1.
- FETCH: two-word read into staging register; → LOAD.
- LOAD: copy staging into `rgb`, pulse `load`, pixel index++; → STREAM, starting the prefetch of the next pixel if one remains.
- STREAM: on `done`: if pixels remain and prefetch is complete → LOAD next cycle; if prefetch is still in flight, LOAD on its completion; if none remain → LATCH.
- LATCH: `strip_rst_n`=0, count `LATCH_CYCLES`; at terminal count pulse `frame_done`; → FETCH (pixel 0) if `loop`=1, else IDLE.
- `done` outside STREAM, or coincident with `load`, is ignored. `start` outside IDLE is ignored.
- `wren` is never driven by this block; SPRAM writes are owned elsewhere and must not occur while `busy`.

## Timing
- SPRAM read: address sampled at edge k, `DO` valid after edge k, captured by this block at edge k+1.
- Start accepted at edge 0 (`addr`←BASE) → edge 1 (`addr`←BASE+1) → edge 2 captures word0 → edge 3 captures word1 → `load` high in the cycle after edge 4; first `load` 4 cycles after start.
- `done` at edge d with prefetch complete → `load` high in the cycle after edge d+1 (1-cycle turnaround).
- Prefetch takes 3 cycles after `load`.
- Latch: `strip_rst_n` low for exactly `LATCH_CYCLES` cycles; `frame_done` in the last one.
- Reset (any time, including mid-frame): state IDLE, `addr`=BASE_ADDR, `rgb`=0, `load`=0, `busy`=0, `frame_done`=0, `strip_rst_n`=0, counters 0.

## Structure
- Shared package `led_pkg`: state enum, `CLK_HZ`=48_000_000, `WORDS_PER_PIXEL`=2, default `LATCH_CYCLES`.
- Sub-module `spram_pixel_reader`: given a pixel base address and a `go` pulse, issues the two addresses, assembles the 24-bit word, and returns a `valid` pulse. Used for both FETCH and prefetch.

## Test plan
- SPRAM model preloaded with word0=16'hCEFF, word1=16'hAB00, NUM_LEDS=1; pulse `start` → `load` 4 cycles later with `rgb`=24'h00CEFF; `done` → LATCH for exactly LATCH_CYCLES, single `frame_done`, IDLE.
- NUM_LEDS=3, distinct pixels, driver model returns `done` 1440 cycles after each `load` → three `load`s with correct `rgb` in order, each 1 cycle after the preceding `done`.
- Driver returns `done` 1 cycle after `load` → next `load` waits for prefetch; no pixel skipped or duplicated.
- `loop`=1 → after `frame_done`, pixel 0 is refetched with no IDLE cycle; `busy` stays high.
- Stray `done` in IDLE and `start` in STREAM → no state change.
- Assert `reset` low mid-STREAM → all outputs reach reset values immediately; the next `start` replays from pixel 0.
